// File: rtl/key_scan.sv
// key_scan: debounces active-low push buttons into press pulses, levels and long-press flags
// Ports: clk; rst_n (sync, active-high reset despite the name); key_in raw active-low keys;
//        key_pulse one-cycle press/repeat pulse; key_level debounced pressed; key_long held past LONG_CNT.
// Define KEY_AUTO_REPEAT_EN to emit repeat pulses every REPEAT_CNT cycles while a key is long-held.
module key_scan #(
  parameter int          NUM_KEYS   = 4,
  parameter logic [19:0] DEB_CNT    = 20'd1000000,
  parameter logic [27:0] LONG_CNT   = 28'd50000000,
  parameter logic [27:0] REPEAT_CNT = 28'd10000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_pulse,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_long
);
  typedef enum logic [2:0] {IDLE, DEB_PRESS, PRESSED, HOLD, DEB_RELEASE} state_t;
  // Terminal counts; parameters of 0 or 1 both collapse to a single cycle.
  localparam logic [19:0] DEB_LAST  = (DEB_CNT > 20'd1) ? DEB_CNT - 20'd1 : 20'd0;
  localparam logic [27:0] LONG_LAST = (LONG_CNT > 28'd1) ? LONG_CNT - 28'd1 : 28'd0;
`ifdef KEY_AUTO_REPEAT_EN
  localparam logic [27:0] REP_LAST  = (REPEAT_CNT > 28'd1) ? REPEAT_CNT - 28'd1 : 28'd0;
`endif
  logic [NUM_KEYS-1:0] sync1, sync2;
  always_ff @(posedge clk)
    if (rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= key_in;
      sync2 <= sync1;
    end
  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    state_t      state;
    logic [19:0] deb_cnt;
    logic [27:0] hold_cnt;
    logic        pulse, level, lng, down;
    assign down         = ~sync2[k];
    assign key_pulse[k] = pulse;
    assign key_level[k] = level;
    assign key_long[k]  = lng;
    // Counters only advance below their terminal value, so they saturate rather than wrap.
    always_ff @(posedge clk)
      if (rst_n) begin
        state    <= IDLE;
        deb_cnt  <= '0;
        hold_cnt <= '0;
        pulse    <= 1'b0;
        level    <= 1'b0;
        lng      <= 1'b0;
      end else begin
        pulse <= 1'b0;
        case (state)
          IDLE:
            if (down) begin
              state   <= DEB_PRESS;
              deb_cnt <= '0;
            end
          DEB_PRESS:
            if (!down) state <= IDLE;
            else if (deb_cnt >= DEB_LAST) begin
              state    <= PRESSED;
              pulse    <= 1'b1;
              level    <= 1'b1;
              hold_cnt <= '0;
            end else deb_cnt <= deb_cnt + 20'd1;
          PRESSED:
            if (!down) begin
              state   <= DEB_RELEASE;
              deb_cnt <= '0;
            end else if (hold_cnt >= LONG_LAST) begin
              state    <= HOLD;
              lng      <= 1'b1;
              hold_cnt <= '0;
            end else hold_cnt <= hold_cnt + 28'd1;
          HOLD:
            if (!down) begin
              state   <= DEB_RELEASE;
              deb_cnt <= '0;
            end
`ifdef KEY_AUTO_REPEAT_EN
            else if (hold_cnt >= REP_LAST) begin
              pulse    <= 1'b1;
              hold_cnt <= '0;
            end else hold_cnt <= hold_cnt + 28'd1;
`endif
          DEB_RELEASE:
            // A bounce back to pressed resumes where we left off; key_long remembers which.
            if (down) begin
              state    <= lng ? HOLD : PRESSED;
              hold_cnt <= '0;
            end else if (deb_cnt >= DEB_LAST) begin
              state <= IDLE;
              level <= 1'b0;
              lng   <= 1'b0;
            end else deb_cnt <= deb_cnt + 20'd1;
          default: state <= IDLE;
        endcase
      end
  end
endmodule

// File: tb/tb_key_scan.sv
// tb_key_scan: directed scoreboard bench for key_scan with DEB_CNT=4, LONG_CNT=10, REPEAT_CNT=3
module tb_key_scan;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] key_in = 4'hf;
  logic [3:0] key_pulse, key_level, key_long;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  typedef struct {int c; logic [3:0] p, l, g;} exp_t;
  exp_t sb[$];
  key_scan #(.NUM_KEYS(4), .DEB_CNT(20'd4), .LONG_CNT(28'd10), .REPEAT_CNT(28'd3)) dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in),
    .key_pulse(key_pulse), .key_level(key_level), .key_long(key_long)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Monitor: every nonzero key_pulse must match the next expected event in cycle and outputs.
  always @(negedge clk)
    if (!rst_n && key_pulse !== 4'b0000) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse cyc=%0d pulse=%b", cyc, key_pulse);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.c != cyc || e.p !== key_pulse || e.l !== key_level || e.g !== key_long) begin
          errors++;
          $display("FAIL pulse_event got cyc=%0d p=%b l=%b g=%b expected cyc=%0d p=%b l=%b g=%b",
                   cyc, key_pulse, key_level, key_long, e.c, e.p, e.l, e.g);
        end
      end
    end
  task automatic push(int c, logic [3:0] p, logic [3:0] l, logic [3:0] g);
    exp_t e;
    e.c = c; e.p = p; e.l = l; e.g = g;
    sb.push_back(e);
  endtask
  task automatic chk(string name, logic [3:0] act, logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cyc=%0d)", name, act, exp, cyc);
    end
  endtask
  task automatic wait_to(int c);
    while (cyc < c) @(negedge clk);
  endtask
  initial begin
    int t0, t1;
    repeat (3) @(negedge clk);
    chk("reset_pulse", key_pulse, 4'b0000);
    chk("reset_level", key_level, 4'b0000);
    chk("reset_long", key_long, 4'b0000);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    // Clean press on key 0
    key_in[0] = 1'b0; t0 = cyc;
    push(t0 + 7, 4'b0001, 4'b0001, 4'b0000);
    wait_to(t0 + 6); chk("clean_level_before", key_level, 4'b0000);
    wait_to(t0 + 8); chk("clean_level_held", key_level, 4'b0001);
    chk("clean_long", key_long, 4'b0000);
    key_in[0] = 1'b1; t1 = cyc;
    wait_to(t1 + 6); chk("clean_rel_level_still", key_level, 4'b0001);
    wait_to(t1 + 7); chk("clean_rel_level_low", key_level, 4'b0000);
    repeat (4) @(negedge clk);
    // Bounce on key 1: never stable for 4 cycles
    for (int i = 0; i < 20; i++) begin
      key_in[1] = (i % 4) < 2 ? 1'b0 : 1'b1;
      @(negedge clk);
    end
    key_in[1] = 1'b1;
    repeat (10) @(negedge clk);
    chk("bounce_level", key_level, 4'b0000);
    // Long hold on key 0
    key_in[0] = 1'b0; t0 = cyc;
    push(t0 + 7, 4'b0001, 4'b0001, 4'b0000);
`ifdef KEY_AUTO_REPEAT_EN
    for (int c = 20; c <= 41; c += 3) push(t0 + c, 4'b0001, 4'b0001, 4'b0001);
`endif
    wait_to(t0 + 16); chk("long_before", key_long, 4'b0000);
    wait_to(t0 + 17); chk("long_asserted", key_long, 4'b0001);
    wait_to(t0 + 40); key_in[0] = 1'b1;
    wait_to(t0 + 46); chk("long_rel_level_still", key_level, 4'b0001);
    chk("long_rel_long_still", key_long, 4'b0001);
    wait_to(t0 + 47); chk("long_rel_level_low", key_level, 4'b0000);
    chk("long_rel_long_low", key_long, 4'b0000);
    repeat (4) @(negedge clk);
    // Release bounce on key 2
    key_in[2] = 1'b0; t0 = cyc;
    push(t0 + 7, 4'b0100, 4'b0100, 4'b0000);
    wait_to(t0 + 9); key_in[2] = 1'b1;
    wait_to(t0 + 11); key_in[2] = 1'b0;
    wait_to(t0 + 15); chk("relbounce_level", key_level, 4'b0100);
    chk("relbounce_long", key_long, 4'b0000);
    key_in[2] = 1'b1; t1 = cyc;
    wait_to(t1 + 6); chk("relbounce_final_still", key_level, 4'b0100);
    wait_to(t1 + 7); chk("relbounce_final_low", key_level, 4'b0000);
    repeat (4) @(negedge clk);
    // Simultaneous press on keys 0 and 3
    key_in = 4'b0110; t0 = cyc;
    push(t0 + 7, 4'b1001, 4'b1001, 4'b0000);
    wait_to(t0 + 9); chk("simul_level", key_level, 4'b1001);
    key_in = 4'b1111;
    repeat (12) @(negedge clk);
    chk("simul_rel_level", key_level, 4'b0000);
    // Reset mid-press on key 0
    key_in[0] = 1'b0; t0 = cyc;
    push(t0 + 13, 4'b0001, 4'b0001, 4'b0000);
    wait_to(t0 + 5); rst_n = 1'b1;
    wait_to(t0 + 6); rst_n = 1'b0;
    chk("rst_mid_level", key_level, 4'b0000);
    wait_to(t0 + 12); chk("rst_mid_level_before", key_level, 4'b0000);
    wait_to(t0 + 14); chk("rst_mid_level_after", key_level, 4'b0001);
    key_in[0] = 1'b1;
    repeat (12) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL missing_pulses: got %0d left expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
